// File: rtl/ca_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ca_core_pkg
//  Description : Shared definitions for the multi-cycle CA core: opcodes,
//                FSM state encoding and instruction field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package ca_core_pkg;

    localparam int c_INSTR_W = 32;

    // Instruction field positions
    localparam int c_OP_LO  = 28;
    localparam int c_RD_LO  = 24;
    localparam int c_RS1_LO = 20;
    localparam int c_RS2_LO = 16;
    localparam int c_IMM_LO = 0;
    localparam int c_IMM_W  = 16;

    // Opcodes; 0xB..0xE decode as NOP
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SLT  = 4'h6,
        OP_ADDI = 4'h7,
        OP_BEQ  = 4'h8,
        OP_JMP  = 4'h9,
        OP_OUT  = 4'hA,
        OP_HALT = 4'hF
    } opcode_e;

    // Control FSM state encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALTED = 3'd5;

    // Sign-extend a 16-bit immediate to the full instruction width
    function automatic logic [c_INSTR_W-1:0] sext16(input logic [c_IMM_W-1:0] v);
        return {{(c_INSTR_W-c_IMM_W){v[c_IMM_W-1]}}, v};
    endfunction

endpackage : ca_core_pkg
`default_nettype wire

// File: rtl/ca_alu.sv
`default_nettype none
// ============================================================================
//  Module      : ca_alu
//  Description : Combinational ALU for the CA core. Produces the register
//                result for ALU/ADDI ops and an equality flag for BEQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module ca_alu
    import ca_core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_eq
);

    logic w_lt;

    assign w_lt = ($signed(i_a) < $signed(i_b));
    assign o_eq = (i_a == i_b);

    // Result selection; non-writing ops leave the result at zero
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, w_lt};
            OP_ADDI: o_result = i_a + i_imm;
            default: o_result = '0;
        endcase
    end

endmodule : ca_alu
`default_nettype wire

// File: rtl/ca_mc_core.sv
`default_nettype none
// ============================================================================
//  Module      : ca_mc_core
//  Description : Multi-cycle CA core. Each instruction walks FETCH, DECODE,
//                EXEC and WB (4 cycles) over an inline loadable IMEM and a
//                register file with r0 hard-wired to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module ca_mc_core
    import ca_core_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 8,
    parameter int IMEM_DEPTH = 32,
    localparam int PC_W      = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_we,
    input  logic [PC_W-1:0]      imem_addr,
    input  logic [c_INSTR_W-1:0] imem_wdata,
    input  logic                 start,
    output logic                 busy,
    output logic                 halted,
    output logic [DATA_W-1:0]    Out_value,
    output logic                 out_valid
);

    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [PC_W-1:0]      r_pc;
    logic [c_INSTR_W-1:0] r_ir;
    logic [DATA_W-1:0]    r_opa;
    logic [DATA_W-1:0]    r_opb;
    logic [DATA_W-1:0]    r_alu_res;
    logic                 r_take_br;
    logic [DATA_W-1:0]    r_out_value;
    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_regs [NUM_REGS];
    logic [c_INSTR_W-1:0] r_imem [IMEM_DEPTH];

    logic [3:0]           w_op;
    logic [RIDX_W-1:0]    w_rd;
    logic [RIDX_W-1:0]    w_rs1;
    logic [RIDX_W-1:0]    w_rs2;
    logic [c_INSTR_W-1:0] w_imm_ext;
    logic [DATA_W-1:0]    w_imm;
    logic [DATA_W-1:0]    w_alu_res;
    logic                 w_alu_eq;
    logic                 w_idle_like;
    logic                 w_imem_wr;
    logic                 w_writes_rd;
    logic [PC_W-1:0]      w_pc_inc;
    logic [PC_W-1:0]      w_br_target;
    logic [PC_W-1:0]      w_jmp_target;
    logic                 w_unused;

    // Field decode; upper register-index bits are ignored
    assign w_op         = r_ir[c_OP_LO +: 4];
    assign w_rd         = r_ir[c_RD_LO  +: RIDX_W];
    assign w_rs1        = r_ir[c_RS1_LO +: RIDX_W];
    assign w_rs2        = r_ir[c_RS2_LO +: RIDX_W];
    assign w_imm_ext    = sext16(r_ir[c_IMM_LO +: c_IMM_W]);
    assign w_imm        = w_imm_ext[DATA_W-1:0];
    assign w_unused     = ^{r_ir, w_imm_ext};

    assign w_idle_like  = (r_state == c_ST_IDLE) || (r_state == c_ST_HALTED);
    assign w_imem_wr    = imem_we && w_idle_like;
    assign w_writes_rd  = (w_op >= OP_ADD) && (w_op <= OP_ADDI);

    // PC arithmetic wraps naturally at PC_W bits
    assign w_pc_inc     = r_pc + PC_W'(1);
    assign w_br_target  = w_pc_inc + r_ir[PC_W-1:0];
    assign w_jmp_target = r_ir[PC_W-1:0];

    assign Out_value    = r_out_value;
    assign out_valid    = r_out_valid;

    ca_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op     (w_op),
        .i_a      (r_opa),
        .i_b      (r_opb),
        .i_imm    (w_imm),
        .o_result (w_alu_res),
        .o_eq     (w_alu_eq)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start is only honoured from IDLE or HALTED
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE,
            c_ST_HALTED: if (start) w_state_next = c_ST_FETCH;
            c_ST_FETCH:  w_state_next = c_ST_DECODE;
            c_ST_DECODE: w_state_next = c_ST_EXEC;
            c_ST_EXEC:   w_state_next = (w_op == OP_HALT) ? c_ST_HALTED : c_ST_WB;
            c_ST_WB:     w_state_next = c_ST_FETCH;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy   = 1'b0;
        halted = 1'b0;
        case (r_state)
            c_ST_FETCH, c_ST_DECODE, c_ST_EXEC, c_ST_WB: busy = 1'b1;
            c_ST_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    // IMEM write port; contents survive reset, writes blocked while running
    always_ff @(posedge clk) begin
        if (w_imem_wr) begin
            r_imem[imem_addr] <= imem_wdata;
        end
    end

    // Register file write-back; r0 is never written so it always reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if ((r_state == c_ST_WB) && w_writes_rd && (w_rd != '0)) begin
            r_regs[w_rd] <= r_alu_res;
        end
    end

    // Datapath sequencing: fetch, operand read, execute latch, PC/OUT update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_alu_res   <= '0;
            r_take_br   <= 1'b0;
            r_out_value <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE,
                c_ST_HALTED: begin
                    if (start) r_pc <= '0;
                end
                c_ST_FETCH: begin
                    r_ir <= r_imem[r_pc];
                end
                c_ST_DECODE: begin
                    r_opa <= (w_rs1 == '0) ? '0 : r_regs[w_rs1];
                    r_opb <= (w_rs2 == '0) ? '0 : r_regs[w_rs2];
                end
                c_ST_EXEC: begin
                    r_alu_res <= w_alu_res;
                    r_take_br <= w_alu_eq;
                end
                c_ST_WB: begin
                    case (w_op)
                        OP_BEQ:  r_pc <= r_take_br ? w_br_target : w_pc_inc;
                        OP_JMP:  r_pc <= w_jmp_target;
                        OP_OUT: begin
                            r_out_value <= r_opa;
                            r_out_valid <= 1'b1;
                            r_pc        <= w_pc_inc;
                        end
                        default: r_pc <= w_pc_inc;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule : ca_mc_core
`default_nettype wire
